// File: rtl/pcie_link_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pcie_link_seq_pkg
// Brief   : State encoding and default timing for the link bring-up sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pcie_link_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_HOSTREL = 3'd2,
        ST_EPREL   = 3'd3,
        ST_TRAIN   = 3'd4,
        ST_UP      = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    localparam int c_HOLD_CYCLES_DEF    = 10;
    localparam int c_STAGGER_CYCLES_DEF = 4;
    localparam int c_TRAIN_TIMEOUT_DEF  = 20000;

endpackage
`default_nettype wire

// File: rtl/pcie_seq_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pcie_seq_cnt
// Brief   : Clearable up-counter with an equality compare against a terminal.
// Revision: 1.0 - initial release
// ============================================================================
module pcie_seq_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_hit
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/pcie_link_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pcie_link_seq
// Brief   : Staggered reset release and link-training watchdog for two VHosts.
// Revision: 1.0 - initial release
// ============================================================================
module pcie_link_seq
    import pcie_link_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = c_HOLD_CYCLES_DEF,
    parameter int STAGGER_CYCLES = c_STAGGER_CYCLES_DEF,
    parameter int TRAIN_TIMEOUT  = c_TRAIN_TIMEOUT_DEF,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 Clk,
    input  logic                 notReset,
    input  logic                 ReqRestart,
    input  logic                 HostLinkUp,
    input  logic                 EpLinkUp,
    output logic                 HostnotReset,
    output logic                 EpnotReset,
    output logic                 DispEn,
    output logic                 LinkUp,
    output logic                 Fatal,
    output logic [2:0]           State,
    output logic [CNT_WIDTH-1:0] CycleCount
);

    // HOLD/HOSTREL leave on the last counted cycle; TRAIN fails once the count equals the timeout.
    localparam logic [CNT_WIDTH-1:0] c_HOLD_TERM  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_STAG_TERM  = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_TRAIN_TERM = CNT_WIDTH'(TRAIN_TIMEOUT);

    state_e                 r_state;
    state_e                 w_next;
    logic                   w_restart;
    logic                   w_clr;
    logic                   w_hit;
    logic [CNT_WIDTH-1:0]   w_term;

    logic                   r_host_nrst, w_host_nrst;
    logic                   r_ep_nrst,   w_ep_nrst;
    logic                   r_disp,      w_disp;
    logic                   r_link,      w_link;
    logic                   r_fatal,     w_fatal;
    logic [CNT_WIDTH-1:0]   r_cyc;

    assign w_restart = ReqRestart && (r_state != ST_IDLE);
    assign w_clr     = (w_next != r_state) || w_restart;

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_HOLD:    w_term = c_HOLD_TERM;
            ST_HOSTREL: w_term = c_STAG_TERM;
            ST_TRAIN:   w_term = c_TRAIN_TERM;
            default:    w_term = '0;
        endcase
    end

    pcie_seq_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk    (Clk),
        .rst_n  (notReset),
        .i_clr  (w_clr),
        .i_term (w_term),
        .o_hit  (w_hit)
    );

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_restart) begin
            w_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_HOLD;
                ST_HOLD:    if (w_hit) w_next = ST_HOSTREL;
                ST_HOSTREL: if (w_hit) w_next = ST_EPREL;
                ST_EPREL:   w_next = ST_TRAIN;
                ST_TRAIN: begin
                    if (HostLinkUp && EpLinkUp) begin
                        w_next = ST_UP;
                    end else if (w_hit) begin
                        w_next = ST_FAIL;
                    end
                end
                ST_UP:      if (!HostLinkUp || !EpLinkUp) w_next = ST_FAIL;
                ST_FAIL:    w_next = ST_FAIL;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as State.
    always_comb begin
        w_host_nrst = r_host_nrst;
        w_ep_nrst   = r_ep_nrst;
        w_disp      = r_disp;
        w_link      = 1'b0;
        w_fatal     = r_fatal;
        case (w_next)
            ST_IDLE, ST_HOLD: begin
                w_host_nrst = 1'b0;
                w_ep_nrst   = 1'b0;
                w_disp      = 1'b0;
            end
            ST_HOSTREL: begin
                w_host_nrst = 1'b1;
                w_ep_nrst   = 1'b0;
                w_disp      = 1'b1;
            end
            ST_EPREL, ST_TRAIN: begin
                w_host_nrst = 1'b1;
                w_ep_nrst   = 1'b1;
                w_disp      = 1'b1;
            end
            ST_UP: begin
                w_host_nrst = 1'b1;
                w_ep_nrst   = 1'b1;
                w_disp      = 1'b1;
                w_link      = 1'b1;
            end
            ST_FAIL: begin
                w_fatal     = 1'b1;
            end
            default: begin
                w_link      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            r_host_nrst <= 1'b0;
            r_ep_nrst   <= 1'b0;
            r_disp      <= 1'b0;
            r_link      <= 1'b0;
            r_fatal     <= 1'b0;
            r_cyc       <= '0;
        end else begin
            r_host_nrst <= w_host_nrst;
            r_ep_nrst   <= w_ep_nrst;
            r_disp      <= w_disp;
            r_link      <= w_link;
            r_fatal     <= w_fatal;
            if (r_cyc != '1) begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    assign HostnotReset = r_host_nrst;
    assign EpnotReset   = r_ep_nrst;
    assign DispEn       = r_disp;
    assign LinkUp       = r_link;
    assign Fatal        = r_fatal;
    assign State        = r_state;
    assign CycleCount   = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_pcie_link_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_pcie_link_seq
// Brief   : Directed bench for pcie_link_seq with three parameterisations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcie_link_seq;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: defaults
    logic a_nrst = 1'b0, a_req = 1'b0, a_hup = 1'b0, a_eup = 1'b0;
    logic a_hn, a_en, a_disp, a_lup, a_fat;
    logic [2:0]  a_st;
    logic [31:0] a_cyc;

    // Instance B: short training timeout
    logic b_nrst = 1'b0, b_req = 1'b0, b_hup = 1'b0, b_eup = 1'b0;
    logic b_hn, b_en, b_disp, b_lup, b_fat;
    logic [2:0]  b_st;
    logic [31:0] b_cyc;

    // Instance C: narrow counters
    logic c_nrst = 1'b0, c_req = 1'b0, c_hup = 1'b1, c_eup = 1'b1;
    logic c_hn, c_en, c_disp, c_lup, c_fat;
    logic [2:0]  c_st;
    logic [3:0]  c_cyc;

    pcie_link_seq u_dut_a (
        .Clk(Clk), .notReset(a_nrst), .ReqRestart(a_req), .HostLinkUp(a_hup), .EpLinkUp(a_eup),
        .HostnotReset(a_hn), .EpnotReset(a_en), .DispEn(a_disp), .LinkUp(a_lup), .Fatal(a_fat),
        .State(a_st), .CycleCount(a_cyc)
    );

    pcie_link_seq #(.TRAIN_TIMEOUT(50)) u_dut_b (
        .Clk(Clk), .notReset(b_nrst), .ReqRestart(b_req), .HostLinkUp(b_hup), .EpLinkUp(b_eup),
        .HostnotReset(b_hn), .EpnotReset(b_en), .DispEn(b_disp), .LinkUp(b_lup), .Fatal(b_fat),
        .State(b_st), .CycleCount(b_cyc)
    );

    pcie_link_seq #(.HOLD_CYCLES(2), .STAGGER_CYCLES(1), .TRAIN_TIMEOUT(5), .CNT_WIDTH(4)) u_dut_c (
        .Clk(Clk), .notReset(c_nrst), .ReqRestart(c_req), .HostLinkUp(c_hup), .EpLinkUp(c_eup),
        .HostnotReset(c_hn), .EpnotReset(c_en), .DispEn(c_disp), .LinkUp(c_lup), .Fatal(c_fat),
        .State(c_st), .CycleCount(c_cyc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #12;
        // Reset values
        check_eq("a_rst_outs", 32'({a_hn, a_en, a_disp, a_lup, a_fat}), 32'd0);
        check_eq("a_rst_state", 32'(a_st), 32'd0);
        check_eq("a_rst_cyc", a_cyc, 32'd0);
        check_eq("c_rst_cyc", 32'(c_cyc), 32'd0);

        // Normal bring-up with defaults
        a_nrst = 1'b1;
        for (int p = 1; p <= 21; p++) begin
            step();
            if (p == 1) begin
                check_eq("a_hold_state", 32'(a_st), 32'd1);
                check_eq("a_cyc_p1", a_cyc, 32'd1);
            end
            if (p == 10) check_eq("a_hn_p10", 32'(a_hn), 32'd0);
            if (p == 11) begin
                check_eq("a_hn_p11", 32'(a_hn), 32'd1);
                check_eq("a_disp_p11", 32'(a_disp), 32'd1);
                check_eq("a_st_p11", 32'(a_st), 32'd2);
            end
            if (p == 14) check_eq("a_en_p14", 32'(a_en), 32'd0);
            if (p == 15) begin
                check_eq("a_en_p15", 32'(a_en), 32'd1);
                check_eq("a_st_p15", 32'(a_st), 32'd3);
            end
            if (p == 16) check_eq("a_st_p16", 32'(a_st), 32'd4);
            if (p == 20) begin
                check_eq("a_lup_p20", 32'(a_lup), 32'd0);
                a_hup = 1'b1;
                a_eup = 1'b1;
            end
            if (p == 21) begin
                check_eq("a_lup_p21", 32'(a_lup), 32'd1);
                check_eq("a_st_p21", 32'(a_st), 32'd5);
                check_eq("a_fat_p21", 32'(a_fat), 32'd0);
            end
        end

        // Link loss in UP, then restart
        step();
        a_eup = 1'b0;
        step();
        check_eq("a_loss_state", 32'(a_st), 32'd6);
        check_eq("a_loss_fatal", 32'(a_fat), 32'd1);
        check_eq("a_loss_lup", 32'(a_lup), 32'd0);
        check_eq("a_loss_held", 32'({a_hn, a_en, a_disp}), 32'b111);
        a_eup = 1'b1;
        a_req = 1'b1;
        step();
        a_req = 1'b0;
        check_eq("a_rs_state", 32'(a_st), 32'd1);
        check_eq("a_rs_resets", 32'({a_hn, a_en, a_disp}), 32'b000);
        check_eq("a_rs_fatal", 32'(a_fat), 32'd1);
        for (int i = 0; i < 40 && a_st != 3'd5; i++) step();
        check_eq("a_reup_state", 32'(a_st), 32'd5);
        check_eq("a_reup_fatal", 32'(a_fat), 32'd1);

        // Async reset mid-cycle while UP
        #2;
        a_nrst = 1'b0;
        #1;
        check_eq("a_async_outs", 32'({a_hn, a_en, a_disp, a_lup, a_fat}), 32'd0);
        check_eq("a_async_state", 32'(a_st), 32'd0);
        #2;
        a_nrst = 1'b1;
        for (int p = 1; p <= 11; p++) begin
            step();
            if (p == 1)  check_eq("a_ar_fatal", 32'(a_fat), 32'd0);
            if (p == 10) check_eq("a_ar_hn_p10", 32'(a_hn), 32'd0);
            if (p == 11) check_eq("a_ar_hn_p11", 32'(a_hn), 32'd1);
        end

        // Training timeout, TRAIN_TIMEOUT=50
        b_nrst = 1'b1;
        for (int p = 1; p <= 67; p++) begin
            step();
            if (p == 16) check_eq("b_train_st", 32'(b_st), 32'd4);
            if (p == 66) begin
                check_eq("b_p66_st", 32'(b_st), 32'd4);
                check_eq("b_p66_fat", 32'(b_fat), 32'd0);
            end
            if (p == 67) begin
                check_eq("b_to_state", 32'(b_st), 32'd6);
                check_eq("b_to_fatal", 32'(b_fat), 32'd1);
                check_eq("b_to_disp", 32'(b_disp), 32'd1);
                check_eq("b_to_lup", 32'(b_lup), 32'd0);
            end
        end

        // Restart in the timeout cycle wins over the timeout
        b_nrst = 1'b0;
        #1;
        check_eq("b_rst_fatal", 32'(b_fat), 32'd0);
        #1;
        b_nrst = 1'b1;
        for (int p = 1; p <= 67; p++) begin
            step();
            if (p == 66) b_req = 1'b1;
            if (p == 67) begin
                b_req = 1'b0;
                check_eq("b_rq_state", 32'(b_st), 32'd1);
                check_eq("b_rq_fatal", 32'(b_fat), 32'd0);
                check_eq("b_rq_resets", 32'({b_hn, b_en, b_disp}), 32'b000);
            end
        end

        // Narrow CycleCount saturation
        c_nrst = 1'b1;
        for (int p = 1; p <= 25; p++) begin
            step();
            if (p == 6) begin
                check_eq("c_up_state", 32'(c_st), 32'd5);
                check_eq("c_up_lup", 32'(c_lup), 32'd1);
            end
            if (p == 14) check_eq("c_cyc_p14", 32'(c_cyc), 32'd14);
            if (p == 15) check_eq("c_cyc_p15", 32'(c_cyc), 32'd15);
            if (p == 25) check_eq("c_cyc_p25", 32'(c_cyc), 32'd15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
